reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Per-register pending-write scoreboard for the 5-stage pipeline.
- Parametrised N-to-2^N one-hot decoders (issue and retire) drive a bank of small per-register counters.
- Hazard logic queries two source registers per cycle and gets busy flags back.
- Sits between decode (issue) and writeback (retire); replaces ad-hoc fixed-width decoders in hazard detection.

Parameters:
- ADDR_W, 5, register address width; NREG = 2**ADDR_W (localparam).
- CNT_W, 2, width of each per-register in-flight write counter; CMAX = 2**CNT_W-1.
- ZERO_REG, 31, hard-wired zero register, never tracked.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode stage requests to mark a destination pending.
- issue_addr  in  ADDR_W  destination register of issuing instruction.
- issue_ready  out  1  issue can be accepted this cycle.
- retire_valid  in  1  writeback completes a write.
- retire_addr  in  ADDR_W  register being written back.
- rd_addr_a  in  ADDR_W  source register A query.
- rd_addr_b  in  ADDR_W  source register B query.
- busy_a  out  1  register rd_addr_a has pending write(s).
- busy_b  out  1  register rd_addr_b has pending write(s).
- busy_vec  out  NREG  bit i = (cnt[i] != 0).
- err  out  1  sticky: retire seen for a register with count 0.

Behaviour:
- Reset (async, immediate): all cnt = 0, err = 0. Consequently busy_vec = 0, busy_a = busy_b = 0 and issue_ready = 1.
- Accepted issue is issue_valid && issue_ready. Retire is always accepted when retire_valid.
- Decode: issue_en = one-hot(issue_addr) gated by the accepted issue; retire_en = one-hot(retire_addr) gated by retire_valid.
- Per register i, next-state update at the clock edge:
  - inc only: cnt+1.
  - dec only with cnt>0: cnt-1.
  - dec only with cnt==0: cnt stays 0, err set to 1.
  - inc and dec same cycle (same register): cnt unchanged; err not set even if cnt==0.
- issue_ready (combinational):
  - 0 iff cnt[issue_addr]==CMAX and NOT (retire_valid && retire_addr==issue_addr).
  - Always 1 when issue_addr==ZERO_REG.
- ZERO_REG: issue and retire to it are no-ops. cnt stays 0, busy bit is 0, and err is never set by it.
- busy_vec is a registered view: it reflects counters after the last edge, with no same-cycle issue forwarding.
- busy_a/busy_b: combinational lookup busy_vec[rd_addr_*] (see optional feature for retire bypass).
- Latency: issue at edge k → busy visible from cycle k+1. Retire at edge k → clear visible from cycle k+1 (without bypass).
- Saturation: counter never wraps. Issue is blocked by issue_ready instead.
- err clears only on reset.
- Reset mid-operation: all pending state discarded; the pipeline is required to flush concurrently.

Optional Feature:
- Macro: SCOREBOARD_BYPASS_EN.
- Defined: busy_a = busy_vec[rd_addr_a] && !(retire_valid && retire_addr==rd_addr_a && cnt[rd_addr_a]==1), same for busy_b. A write retiring this cycle unblocks its consumer one cycle earlier; writeback-to-decode forwarding must exist.
- Undefined: pure registered lookup; consumer waits one extra cycle.

Decomposition:
- Package sb_pkg holds:
  - ADDR_W default and ZERO_REG constant.
  - typedef reg_addr_t (logic [ADDR_W-1:0]).
  - typedef cnt_t (logic [CNT_W-1:0]).
- Sub-module decoder_n: parametrised ADDR_W → 2**ADDR_W one-hot, with an enable input; all-zero output when disabled. Instantiated twice (issue, retire).
- Counter bank and query muxes stay in reg_scoreboard.

Test Plan:
- Reset, then query rd_addr_a=3, rd_addr_b=0 → busy_a=0, busy_b=0, busy_vec=0, issue_ready=1, err=0.
- Issue addr 5 in cycle 1 → busy_vec[5]=1 from cycle 2; query rd_addr_a=5 → busy_a=1. Retire 5 → busy_a=0 next cycle (same cycle with SCOREBOARD_BYPASS_EN).
- Issue addr 7 three times (CNT_W=2) → cnt=3, issue_ready=0 for addr 7. Re-drive issue 7 together with retire 7 → issue_ready=1 and cnt stays 3. Retire three times with no issue → busy_vec[7]=0.
- Issue 31 and retire 31 in any mix → busy_vec[31]=0, issue_ready=1, err=0.
- Retire addr 9 with cnt=0 → err=1 next cycle and stays 1. Assert reset mid-cycle → err=0 and busy_vec=0 immediately, without waiting for clk.
- Same cycle: issue 4 and retire 4 with cnt[4]=1 → cnt[4] stays 1, busy_vec[4]=1. Issue 2 and retire 4 simultaneously → busy_vec[2]=1, busy_vec[4]=0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared constants and types for the register pending-write scoreboard.
package sb_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/retire/query bundle between the pipeline (master) and the scoreboard (slave).
interface reg_scoreboard_if #(
  parameter int unsigned ADDR_W = sb_pkg::ADDR_W
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_ready;
  logic              retire_valid;
  logic [ADDR_W-1:0] retire_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              busy_a;
  logic              busy_b;
  logic [NREG-1:0]   busy_vec;
  logic              err;

  modport master (
    output issue_valid, issue_addr, retire_valid, retire_addr, rd_addr_a, rd_addr_b,
    input  issue_ready, busy_a, busy_b, busy_vec, err
  );

  modport slave (
    input  issue_valid, issue_addr, retire_valid, retire_addr, rd_addr_a, rd_addr_b,
    output issue_ready, busy_a, busy_b, busy_vec, err
  );

endinterface

// File: rtl/decoder_n.sv
// ADDR_W-bit address to 2**ADDR_W one-hot decoder; all zeros when disabled.
module decoder_n #(
  parameter int unsigned ADDR_W = sb_pkg::ADDR_W
) (
  input  logic                   en_i,
  input  logic [ADDR_W-1:0]      addr_i,
  output logic [2**ADDR_W-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with two-port busy query and sticky underflow error.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle final retire clear busy_a/busy_b.
module reg_scoreboard #(
  parameter int unsigned ADDR_W   = sb_pkg::ADDR_W,
  parameter int unsigned CNT_W    = sb_pkg::CNT_W,
  parameter int unsigned ZERO_REG = sb_pkg::ZERO_REG
) (
  input logic             clk,
  input logic             reset,
  reg_scoreboard_if.slave sb
);

  localparam int unsigned       NREG     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CntMax   = '1;
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [NREG-1:0]            issue_en, retire_en, busy;
  logic                       issue_ready, issue_acc, retire_acc;

  // A full counter can still take an issue if the same register retires this cycle.
  always_comb begin
    issue_ready = 1'b1;
    if (sb.issue_addr != ZeroAddr && cnt_q[sb.issue_addr] == CntMax) begin
      issue_ready = sb.retire_valid && (sb.retire_addr == sb.issue_addr);
    end
    issue_acc  = sb.issue_valid && issue_ready && (sb.issue_addr != ZeroAddr);
    retire_acc = sb.retire_valid && (sb.retire_addr != ZeroAddr);
  end

  decoder_n #(.ADDR_W(ADDR_W)) u_issue_dec (
    .en_i     (issue_acc),
    .addr_i   (sb.issue_addr),
    .onehot_o (issue_en)
  );

  decoder_n #(.ADDR_W(ADDR_W)) u_retire_dec (
    .en_i     (retire_acc),
    .addr_i   (sb.retire_addr),
    .onehot_o (retire_en)
  );

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      case ({issue_en[i], retire_en[i]})
        2'b10: cnt_d[i] = cnt_q[i] + CntOne;
        2'b01: begin
          if (cnt_q[i] == '0) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CntOne;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
    sb.busy_vec    = busy;
    sb.err         = err_q;
    sb.issue_ready = issue_ready;
    sb.busy_a      = busy[sb.rd_addr_a];
    sb.busy_b      = busy[sb.rd_addr_b];
`ifdef SCOREBOARD_BYPASS_EN
    if (sb.retire_valid && sb.retire_addr == sb.rd_addr_a && cnt_q[sb.rd_addr_a] == CntOne) begin
      sb.busy_a = 1'b0;
    end
    if (sb.retire_valid && sb.retire_addr == sb.rd_addr_b && cnt_q[sb.rd_addr_b] == CntOne) begin
      sb.busy_b = 1'b0;
    end
`else
`endif
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: driver pushes expected outputs from a counter-array model, monitor checks.
module tb_reg_scoreboard;
  import sb_pkg::*;

  localparam int NR   = 32;
  localparam int CMAX = 3;
  localparam int ZR   = 31;

  typedef struct {
    logic        ready;
    logic        ba;
    logic        bb;
    logic [31:0] bv;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  reg_scoreboard_if sb_if ();

  reg_scoreboard u_dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  int   checks = 0;
  int   errors = 0;
  int   cnt_m [NR];
  bit   err_m;
  exp_t exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(int ia, bit rv, int ra);
    if (ia == ZR || cnt_m[ia] < CMAX) return 1'b1;
    return rv && (ra == ia);
  endfunction

  function automatic bit m_busy(int a, bit rv, int ra);
    bit b;
    b = (cnt_m[a] != 0);
`ifdef SCOREBOARD_BYPASS_EN
    if (rv && ra == a && cnt_m[a] == 1) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic m_update(bit inc, int ia, bit rv, int ra);
    bit dec;
    inc = inc && (ia != ZR);
    dec = rv && (ra != ZR);
    if (inc && dec && ia == ra) return;
    if (inc) cnt_m[ia]++;
    if (dec) begin
      if (cnt_m[ra] > 0) cnt_m[ra]--;
      else err_m = 1'b1;
    end
  endtask

  task automatic step(input bit iv, input int ia, input bit rv, input int ra,
                      input int a, input int b);
    exp_t e;
    @(negedge clk);
    sb_if.issue_valid  = iv;
    sb_if.issue_addr   = reg_addr_t'(ia);
    sb_if.retire_valid = rv;
    sb_if.retire_addr  = reg_addr_t'(ra);
    sb_if.rd_addr_a    = reg_addr_t'(a);
    sb_if.rd_addr_b    = reg_addr_t'(b);
    e.ready = m_ready(ia, rv, ra);
    e.ba    = m_busy(a, rv, ra);
    e.bb    = m_busy(b, rv, ra);
    for (int i = 0; i < NR; i++) e.bv[i] = (cnt_m[i] != 0);
    e.err   = err_m;
    exp_q.push_back(e);
    m_update(iv && e.ready, ia, rv, ra);
  endtask

  // Monitor: outputs are combinational, so sample mid-low-phase once the driver has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_ready", 32'(sb_if.issue_ready), 32'(e.ready));
        chk("busy_a", 32'(sb_if.busy_a), 32'(e.ba));
        chk("busy_b", 32'(sb_if.busy_b), 32'(e.bb));
        chk("busy_vec", sb_if.busy_vec, e.bv);
        chk("err", 32'(sb_if.err), 32'(e.err));
      end
    end
  end

  function automatic int pick_addr();
    int pool [6] = '{5, 7, 9, 31, 4, 2};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
    return int'($urandom_range(0, NR - 1));
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    #3;
  endtask

  initial begin
    int ia, ra, a, b;
    bit iv, rv;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    err_m = 1'b0;
    sb_if.issue_valid  = 1'b0;
    sb_if.issue_addr   = '0;
    sb_if.retire_valid = 1'b0;
    sb_if.retire_addr  = '0;
    sb_if.rd_addr_a    = '0;
    sb_if.rd_addr_b    = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("reset_busy_vec", sb_if.busy_vec, 32'd0);
    chk("reset_err", 32'(sb_if.err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    step(0, 0, 0, 0, 3, 0);
    // Single issue / retire latency on register 5.
    step(1, 5, 0, 0, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    step(0, 0, 1, 5, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    // Saturate register 7, then issue with concurrent retire, then drain it.
    repeat (3) step(1, 7, 0, 0, 7, 0);
    step(1, 7, 0, 0, 7, 7);
    step(1, 7, 1, 7, 7, 0);
    repeat (3) step(0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 0, 7, 31);
    // Zero register is never tracked.
    step(1, 31, 1, 31, 31, 31);
    step(1, 31, 0, 0, 31, 0);
    step(0, 0, 1, 31, 31, 0);
    step(1, 31, 0, 0, 31, 31);
    // Same-cycle issue/retire on one register, and on different registers.
    step(1, 4, 0, 0, 4, 2);
    step(1, 4, 1, 4, 4, 2);
    step(1, 2, 1, 4, 2, 4);
    step(0, 0, 0, 0, 2, 4);
    step(0, 0, 1, 2, 2, 4);
    // Underflow sets the sticky error.
    step(0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 0, 9, 0);
    step(1, 9, 0, 0, 9, 0);
    step(0, 0, 1, 9, 9, 0);

    for (int n = 0; n < 3000; n++) begin
      ia = pick_addr();
      ra = pick_addr();
      iv = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 40);
      a  = ($urandom_range(0, 3) == 0) ? ra : pick_addr();
      b  = ($urandom_range(0, 3) == 0) ? ia : pick_addr();
      step(iv, ia, rv, ra, a, b);
    end
    step(1, 6, 0, 0, 6, 9);
    step(0, 0, 0, 0, 6, 9);
    drain();

    // Asynchronous reset between clock edges.
    sb_if.issue_valid  = 1'b0;
    sb_if.retire_valid = 1'b0;
    sb_if.issue_addr   = reg_addr_t'(6);
    @(posedge clk);
    #3;
    chk("pre_reset_err", 32'(sb_if.err), 32'(err_m));
    chk("pre_reset_busy6", 32'(sb_if.busy_vec[6]), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_err", 32'(sb_if.err), 32'd0);
    chk("async_reset_busy_vec", sb_if.busy_vec, 32'd0);
    chk("async_reset_ready", 32'(sb_if.issue_ready), 32'd1);
    foreach (cnt_m[i]) cnt_m[i] = 0;
    err_m = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1, 5, 0, 0, 5, 9);
    step(0, 0, 1, 5, 5, 9);
    step(0, 0, 0, 0, 5, 9);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
